fifo_param: RTL and testbench

FIFO_PARAM -- requirements
Module: fifo_param

---
 rtl/fifo_param_if.sv | 36 +++
 rtl/fifo_param.sv | 117 +++++++++++
 tb/tb_fifo_param.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_param_if.sv
// fifo_param_if -- handshake and status bundle for fifo_param.
// The master side issues write/read requests and thresholds; the slave side
// (the FIFO) returns read data, occupancy and status flags.
interface fifo_param_if #(
    parameter int unsigned DATA_SIZE = 12,
    parameter int unsigned ADDR_SIZE = 2
);
    // Requests and configuration from the producer/consumer side
    logic                 write;
    logic                 read;
    logic [DATA_SIZE-1:0] data_in;
    logic [ADDR_SIZE:0]   th_almost_full;
    logic [ADDR_SIZE:0]   th_almost_empty;

    // Results and status from the FIFO
    logic [DATA_SIZE-1:0] fifo_data_out;
    logic                 fifo_valid;
    logic [ADDR_SIZE:0]   fifo_count;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 fifo_pause;
    logic                 fifo_almost_empty;
    logic                 fifo_error;

    modport master (
        output write, read, data_in, th_almost_full, th_almost_empty,
        input  fifo_data_out, fifo_valid, fifo_count, fifo_empty, fifo_full,
               fifo_pause, fifo_almost_empty, fifo_error
    );

    modport slave (
        input  write, read, data_in, th_almost_full, th_almost_empty,
        output fifo_data_out, fifo_valid, fifo_count, fifo_empty, fifo_full,
               fifo_pause, fifo_almost_empty, fifo_error
    );
endinterface

// File: rtl/fifo_param.sv
// fifo_param -- single-clock synchronous FIFO, DEPTH = 2**ADDR_SIZE words.
// Registered read data (latency 1) with a one-cycle fifo_valid strobe,
// registered occupancy count, and status flags decoded from that count.
// Optional build macro FIFO_ERR_STICKY_EN: when defined, fifo_error latches
// on the first overflow/underflow event and holds until reset; otherwise it
// pulses for one cycle per event.
module fifo_param #(
    parameter int unsigned DATA_SIZE = 12,
    parameter int unsigned ADDR_SIZE = 2
) (
    input  logic          clk,
    input  logic          reset,
    fifo_param_if.slave   bus
);

    localparam int unsigned        DEPTH   = 1 << ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] C_DEPTH = (ADDR_SIZE + 1)'(DEPTH);

    // Storage and pointers; pointer width gives natural DEPTH-1 -> 0 wrap
    logic [DATA_SIZE-1:0] r_mem [DEPTH];
    logic [ADDR_SIZE-1:0] r_wr_ptr;
    logic [ADDR_SIZE-1:0] r_rd_ptr;
    logic [ADDR_SIZE:0]   r_count;
    logic [DATA_SIZE-1:0] r_data_out;
    logic                 r_valid;
    logic                 r_error;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_wr_accept;
    logic                 w_rd_accept;
    logic                 w_err_event;
    logic [ADDR_SIZE:0]   w_count_nxt;

    // Status decoded from the registered count only
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == C_DEPTH);

    // A request is honoured only when the FIFO can service it; on full with
    // both requests the read drains a slot and the write is dropped, and on
    // empty with both requests the write lands while the read is dropped.
    assign w_wr_accept = bus.write && !w_full;
    assign w_rd_accept = bus.read  && !w_empty;
    assign w_err_event = (bus.write && w_full) || (bus.read && w_empty);

    // Next occupancy: +1 write-only, -1 read-only, otherwise unchanged
    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_wr_accept, w_rd_accept})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Memory write port; contents are not reset, stale words become
    // unreachable once the pointers are cleared
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr] <= bus.data_in;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_accept) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
        end
    end

    // Registered read data and its one-cycle valid strobe; data holds
    // its last value when no read is accepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data_out <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= w_rd_accept;
            if (w_rd_accept) begin
                r_data_out <= r_mem[r_rd_ptr];
            end
        end
    end

    // Overflow/underflow indication, visible the cycle after the event
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_error <= 1'b0;
        end else begin
`ifdef FIFO_ERR_STICKY_EN
            r_error <= r_error | w_err_event;
`else
            r_error <= w_err_event;
`endif
        end
    end

    assign bus.fifo_data_out     = r_data_out;
    assign bus.fifo_valid        = r_valid;
    assign bus.fifo_count        = r_count;
    assign bus.fifo_empty        = w_empty;
    assign bus.fifo_full         = w_full;
    assign bus.fifo_pause        = (r_count >= bus.th_almost_full);
    assign bus.fifo_almost_empty = (r_count <= bus.th_almost_empty);
    assign bus.fifo_error        = r_error;

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param -- self-checking bench for fifo_param (DATA_SIZE=12, ADDR_SIZE=2).
// A queue model tracks stored words; read results are pushed to a scoreboard
// when a read is issued and popped when the DUT strobes fifo_valid.
module tb_fifo_param;
    localparam int unsigned DW    = 12;
    localparam int unsigned AW    = 2;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fifo_param_if #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) bus ();

    fifo_param #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model state
    logic [DW-1:0] m_q[$];     // words held in the FIFO
    logic [DW-1:0] m_sb[$];    // scoreboard: read results still to appear
    int unsigned   m_count;
    logic          m_valid;
    logic          m_err;
    logic [DW-1:0] m_data;     // last word presented on fifo_data_out

    task automatic model_reset();
        m_q.delete();
        m_sb.delete();
        m_count = 0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_data  = '0;
    endtask

    // Apply one edge of stimulus, advance the model, return #1 after the edge
    task automatic drive_edge(input logic w, input logic r, input logic [DW-1:0] d);
        logic full, empty, wa, ra, ev;
        @(negedge clk);
        bus.write   = w;
        bus.read    = r;
        bus.data_in = d;
        full  = (m_count == DEPTH);
        empty = (m_count == 0);
        wa    = w && !full;
        ra    = r && !empty;
        ev    = (w && full) || (r && empty);
        if (ra) m_sb.push_back(m_q.pop_front());
        if (wa) m_q.push_back(d);
        if (wa && !ra) m_count++;
        else if (ra && !wa) m_count--;
        m_valid = ra;
`ifdef FIFO_ERR_STICKY_EN
        m_err = m_err | ev;
`else
        m_err = ev;
`endif
        @(posedge clk);
        #1;
        bus.write = 1'b0;
        bus.read  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.write = 1'b1;
        bus.read = 1'b0;
        bus.data_in = 12'hFFF;
        bus.th_almost_full = 3'd3;
        bus.th_almost_empty = 3'd1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (bus.fifo_count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bus.fifo_count); end
        n_vec++; if (bus.fifo_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", bus.fifo_empty); end
        n_vec++; if (bus.fifo_full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", bus.fifo_full); end
        n_vec++; if (bus.fifo_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.fifo_valid); end
        n_vec++; if (bus.fifo_error !== 1'b0) begin n_err++; $display("FAIL reset_error: got %b want 0", bus.fifo_error); end
        n_vec++; if (bus.fifo_data_out !== 12'h000) begin n_err++; $display("FAIL reset_data: got %h want 000", bus.fifo_data_out); end
        @(negedge clk);
        reset = 1'b0;
        bus.write = 1'b0;
        model_reset();
        drive_edge(1'b0, 1'b0, '0);
        n_vec++; if (bus.fifo_count !== 3'd0) begin n_err++; $display("FAIL reset_write_ignored: count got %0d want 0", bus.fifo_count); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 4; i++) begin
            drive_edge(1'b1, 1'b0, 12'(i));
            n_vec++; if (bus.fifo_count !== 3'(m_count)) begin n_err++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, bus.fifo_count, m_count); end
            n_vec++; if (bus.fifo_pause !== (m_count >= 3)) begin n_err++; $display("FAIL fill_pause[%0d]: got %b want %b", i, bus.fifo_pause, m_count >= 3); end
            n_vec++; if (bus.fifo_full !== (m_count == DEPTH)) begin n_err++; $display("FAIL fill_full[%0d]: got %b want %b", i, bus.fifo_full, m_count == DEPTH); end
            n_vec++; if (bus.fifo_almost_empty !== (m_count <= 1)) begin n_err++; $display("FAIL fill_aempty[%0d]: got %b want %b", i, bus.fifo_almost_empty, m_count <= 1); end
            n_vec++; if (bus.fifo_error !== 1'b0) begin n_err++; $display("FAIL fill_error[%0d]: got %b want 0", i, bus.fifo_error); end
            n_vec++; if (bus.fifo_valid !== 1'b0) begin n_err++; $display("FAIL fill_valid[%0d]: got %b want 0", i, bus.fifo_valid); end
        end
    endtask

    task automatic test_drain();
        logic [DW-1:0] exp_d;
        for (int i = 1; i <= 4; i++) begin
            drive_edge(1'b0, 1'b1, '0);
            n_vec++; if (bus.fifo_valid !== 1'b1) begin n_err++; $display("FAIL drain_valid[%0d]: got %b want 1", i, bus.fifo_valid); end
            exp_d = (m_sb.size() != 0) ? m_sb.pop_front() : 12'hXXX;
            m_data = exp_d;
            n_vec++; if (bus.fifo_data_out !== exp_d) begin n_err++; $display("FAIL drain_data[%0d]: got %h want %h", i, bus.fifo_data_out, exp_d); end
            n_vec++; if (bus.fifo_count !== 3'(m_count)) begin n_err++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, bus.fifo_count, m_count); end
            n_vec++; if (bus.fifo_almost_empty !== (m_count <= 1)) begin n_err++; $display("FAIL drain_aempty[%0d]: got %b want %b", i, bus.fifo_almost_empty, m_count <= 1); end
            n_vec++; if (bus.fifo_empty !== (m_count == 0)) begin n_err++; $display("FAIL drain_empty[%0d]: got %b want %b", i, bus.fifo_empty, m_count == 0); end
        end
        drive_edge(1'b0, 1'b0, '0);
        n_vec++; if (bus.fifo_valid !== 1'b0) begin n_err++; $display("FAIL drain_idle_valid: got %b want 0", bus.fifo_valid); end
        n_vec++; if (bus.fifo_data_out !== 12'h004) begin n_err++; $display("FAIL drain_hold_data: got %h want 004", bus.fifo_data_out); end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] exp_d;
        for (int i = 0; i < 4; i++) drive_edge(1'b1, 1'b0, 12'h021 + 12'(i));
        drive_edge(1'b1, 1'b0, 12'h0AA);
        n_vec++; if (bus.fifo_count !== 3'd4) begin n_err++; $display("FAIL ovf_count: got %0d want 4", bus.fifo_count); end
        n_vec++; if (bus.fifo_error !== 1'b1) begin n_err++; $display("FAIL ovf_error: got %b want 1", bus.fifo_error); end
        drive_edge(1'b0, 1'b0, '0);
        n_vec++; if (bus.fifo_error !== m_err) begin n_err++; $display("FAIL ovf_error_after: got %b want %b", bus.fifo_error, m_err); end
        // Full with both requests: read wins, write dropped, overflow flagged
        drive_edge(1'b1, 1'b1, 12'h0BB);
        n_vec++; if (bus.fifo_count !== 3'd3) begin n_err++; $display("FAIL ovf_rw_count: got %0d want 3", bus.fifo_count); end
        n_vec++; if (bus.fifo_error !== 1'b1) begin n_err++; $display("FAIL ovf_rw_error: got %b want 1", bus.fifo_error); end
        for (int i = 0; i < 4; i++) begin
            if (i != 0) drive_edge(1'b0, 1'b1, '0);
            n_vec++; if (bus.fifo_valid !== 1'b1) begin n_err++; $display("FAIL ovf_drain_valid[%0d]: got %b want 1", i, bus.fifo_valid); end
            exp_d = (m_sb.size() != 0) ? m_sb.pop_front() : 12'hXXX;
            m_data = exp_d;
            n_vec++; if (bus.fifo_data_out !== exp_d) begin n_err++; $display("FAIL ovf_drain_data[%0d]: got %h want %h", i, bus.fifo_data_out, exp_d); end
        end
        n_vec++; if (bus.fifo_empty !== 1'b1) begin n_err++; $display("FAIL ovf_drain_empty: got %b want 1", bus.fifo_empty); end
        n_vec++; if (bus.fifo_error !== m_err) begin n_err++; $display("FAIL ovf_drain_error: got %b want %b", bus.fifo_error, m_err); end
    endtask

    task automatic test_underflow_simul();
        logic [DW-1:0] exp_d;
        drive_edge(1'b0, 1'b1, '0);
        n_vec++; if (bus.fifo_valid !== 1'b0) begin n_err++; $display("FAIL udf_valid: got %b want 0", bus.fifo_valid); end
        n_vec++; if (bus.fifo_error !== 1'b1) begin n_err++; $display("FAIL udf_error: got %b want 1", bus.fifo_error); end
        n_vec++; if (bus.fifo_data_out !== m_data) begin n_err++; $display("FAIL udf_hold_data: got %h want %h", bus.fifo_data_out, m_data); end
        drive_edge(1'b1, 1'b1, 12'h555);
        n_vec++; if (bus.fifo_count !== 3'd1) begin n_err++; $display("FAIL simul_empty_count: got %0d want 1", bus.fifo_count); end
        n_vec++; if (bus.fifo_valid !== 1'b0) begin n_err++; $display("FAIL simul_empty_valid: got %b want 0", bus.fifo_valid); end
        n_vec++; if (bus.fifo_error !== 1'b1) begin n_err++; $display("FAIL simul_empty_error: got %b want 1", bus.fifo_error); end
        drive_edge(1'b1, 1'b0, 12'h556);
        n_vec++; if (bus.fifo_error !== m_err) begin n_err++; $display("FAIL simul_error_clear: got %b want %b", bus.fifo_error, m_err); end
        drive_edge(1'b1, 1'b1, 12'h557);
        n_vec++; if (bus.fifo_count !== 3'd2) begin n_err++; $display("FAIL simul_mid_count: got %0d want 2", bus.fifo_count); end
        for (int i = 0; i < 3; i++) begin
            if (i != 0) drive_edge(1'b0, 1'b1, '0);
            n_vec++; if (bus.fifo_valid !== 1'b1) begin n_err++; $display("FAIL simul_valid[%0d]: got %b want 1", i, bus.fifo_valid); end
            exp_d = (m_sb.size() != 0) ? m_sb.pop_front() : 12'hXXX;
            m_data = exp_d;
            n_vec++; if (bus.fifo_data_out !== exp_d) begin n_err++; $display("FAIL simul_data[%0d]: got %h want %h", i, bus.fifo_data_out, exp_d); end
        end
        n_vec++; if (bus.fifo_count !== 3'd0) begin n_err++; $display("FAIL simul_final_count: got %0d want 0", bus.fifo_count); end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] exp_d;
        drive_edge(1'b1, 1'b0, 12'h010);
        for (int i = 1; i <= 7; i++) begin
            if (i <= 6) drive_edge(1'b1, 1'b1, 12'h010 + 12'(i));
            else        drive_edge(1'b0, 1'b1, '0);
            n_vec++; if (bus.fifo_count !== 3'(m_count)) begin n_err++; $display("FAIL wrap_count[%0d]: got %0d want %0d", i, bus.fifo_count, m_count); end
            n_vec++; if (bus.fifo_valid !== 1'b1) begin n_err++; $display("FAIL wrap_valid[%0d]: got %b want 1", i, bus.fifo_valid); end
            exp_d = (m_sb.size() != 0) ? m_sb.pop_front() : 12'hXXX;
            m_data = exp_d;
            n_vec++; if (bus.fifo_data_out !== exp_d) begin n_err++; $display("FAIL wrap_data[%0d]: got %h want %h", i, bus.fifo_data_out, exp_d); end
            n_vec++; if (bus.fifo_error !== m_err) begin n_err++; $display("FAIL wrap_error[%0d]: got %b want %b", i, bus.fifo_error, m_err); end
        end
    endtask

    task automatic test_async_reset();
        logic [DW-1:0] exp_d;
        for (int i = 0; i < 4; i++) drive_edge(1'b1, 1'b0, 12'h031 + 12'(i));
        drive_edge(1'b1, 1'b1, 12'h035);
        exp_d = (m_sb.size() != 0) ? m_sb.pop_front() : 12'hXXX;
        n_vec++; if (bus.fifo_data_out !== exp_d || bus.fifo_valid !== 1'b1 || bus.fifo_error !== 1'b1 || bus.fifo_count !== 3'd3)
            begin n_err++; $display("FAIL arst_pre: data %h valid %b err %b count %0d want %h 1 1 3", bus.fifo_data_out, bus.fifo_valid, bus.fifo_error, bus.fifo_count, exp_d); end
        #2;
        reset = 1'b1;
        #1;
        n_vec++; if (bus.fifo_count !== 3'd0) begin n_err++; $display("FAIL arst_count: got %0d want 0", bus.fifo_count); end
        n_vec++; if (bus.fifo_empty !== 1'b1) begin n_err++; $display("FAIL arst_empty: got %b want 1", bus.fifo_empty); end
        n_vec++; if (bus.fifo_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid: got %b want 0", bus.fifo_valid); end
        n_vec++; if (bus.fifo_error !== 1'b0) begin n_err++; $display("FAIL arst_error: got %b want 0", bus.fifo_error); end
        n_vec++; if (bus.fifo_data_out !== 12'h000) begin n_err++; $display("FAIL arst_data: got %h want 000", bus.fifo_data_out); end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        drive_edge(1'b1, 1'b0, 12'h777);
        drive_edge(1'b0, 1'b1, '0);
        n_vec++; if (bus.fifo_valid !== 1'b1) begin n_err++; $display("FAIL arst_after_valid: got %b want 1", bus.fifo_valid); end
        exp_d = (m_sb.size() != 0) ? m_sb.pop_front() : 12'hXXX;
        n_vec++; if (bus.fifo_data_out !== exp_d) begin n_err++; $display("FAIL arst_after_data: got %h want %h", bus.fifo_data_out, exp_d); end
        n_vec++; if (bus.fifo_count !== 3'd0 || bus.fifo_empty !== 1'b1) begin n_err++; $display("FAIL arst_after_count: got %0d/%b want 0/1", bus.fifo_count, bus.fifo_empty); end
        n_vec++; if (m_sb.size() != 0) begin n_err++; $display("FAIL scoreboard_left: got %0d want 0", m_sb.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_overflow();
        test_underflow_simul();
        test_wrap();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
